// File: rtl/ysyx_22041752_rf_scb_pkg.sv
// Shared register-file geometry; these values are the defaults for the rf parameters.
package ysyx_22041752_rf_scb_pkg;

  localparam int RF_DATA_WD = 64;
  localparam int RF_ADDR_WD = 5;
  localparam int RF_NUM     = 2 ** RF_ADDR_WD;

endpackage

// File: rtl/ysyx_22041752_rf_busy.sv
// Per-register busy scoreboard: set by issue, cleared by writeback, wiped by flush.
module ysyx_22041752_rf_busy #(
  parameter int NUM = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NUM-1:0] set_vec,
  input  logic [NUM-1:0] clr_vec,
  input  logic           flush,
  output logic [NUM-1:0] busy
);

  // Set is applied after clear so a new producer overrides a retiring one; flush beats both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
    end
  end

endmodule

// File: rtl/ysyx_22041752_rf_scb.sv
// Multi-port register file with same-cycle bypass, busy scoreboard and difftest image.
module ysyx_22041752_rf_scb
  import ysyx_22041752_rf_scb_pkg::*;
#(
  parameter int DATA_WD = RF_DATA_WD,
  parameter int ADDR_WD = RF_ADDR_WD,
  parameter int NR      = 2,
  parameter int NW      = 2,
  parameter int BYPASS  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NR*ADDR_WD-1:0]             raddr,
  output logic [NR*DATA_WD-1:0]             rdata,
  output logic [NR-1:0]                     rbusy,
  input  logic [NW-1:0]                     we,
  input  logic [NW*ADDR_WD-1:0]             waddr,
  input  logic [NW*DATA_WD-1:0]             wdata,
  input  logic                              issue_valid,
  input  logic [ADDR_WD-1:0]                issue_rd,
  output logic                              issue_waw,
  input  logic                              flush,
  output logic [(2**ADDR_WD)*DATA_WD-1:0]   dpi_regs
);

  localparam int NUM = 2 ** ADDR_WD;

  logic [DATA_WD-1:0] regs [NUM];
  logic [NUM-1:0]     busy;
  logic [NUM-1:0]     set_vec;
  logic [NUM-1:0]     clr_vec;

  // Register array: x0 is a constant, every other entry takes the highest-index matching port.
  for (genvar i = 0; i < NUM; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_live
      logic               wr;
      logic [DATA_WD-1:0] wval;
      logic [DATA_WD-1:0] q;

      // Later ports overwrite earlier matches, giving port NW-1 the highest priority.
      always_comb begin
        wr   = 1'b0;
        wval = '0;
        for (int unsigned j = 0; j < NW; j++) begin
          if (we[j] && (waddr[j*ADDR_WD +: ADDR_WD] == ADDR_WD'(i))) begin
            wr   = 1'b1;
            wval = wdata[j*DATA_WD +: DATA_WD];
          end
        end
      end

      // Register storage with asynchronous clear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (wr) begin
          q <= wval;
        end
      end

      assign regs[i] = q;
    end
    assign dpi_regs[i*DATA_WD +: DATA_WD] = regs[i];
  end

  // Read ports: optional forwarding of the in-flight write, and the busy lookup it masks.
  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [ADDR_WD-1:0] ra;
    logic               hit;
    logic [DATA_WD-1:0] val;

    assign ra = raddr[k*ADDR_WD +: ADDR_WD];

    // Scan ports low to high so the highest matching writer supplies the forwarded value.
    always_comb begin
      hit = 1'b0;
      val = regs[ra];
      if ((BYPASS != 0) && (ra != '0)) begin
        for (int unsigned j = 0; j < NW; j++) begin
          if (we[j] && (waddr[j*ADDR_WD +: ADDR_WD] == ra)) begin
            hit = 1'b1;
            val = wdata[j*DATA_WD +: DATA_WD];
          end
        end
      end
    end

    assign rdata[k*DATA_WD +: DATA_WD] = val;
    assign rbusy[k]                    = busy[ra] & ~hit;
  end

  // Scoreboard update requests: issue marks a destination, any write port retires one.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && (issue_rd != '0)) begin
      set_vec[issue_rd] = 1'b1;
    end
    for (int unsigned j = 0; j < NW; j++) begin
      if (we[j]) begin
        clr_vec[waddr[j*ADDR_WD +: ADDR_WD]] = 1'b1;
      end
    end
  end

  ysyx_22041752_rf_busy #(
    .NUM (NUM)
  ) u_busy (
    .clk     (clk),
    .rst     (rst),
    .set_vec (set_vec),
    .clr_vec (clr_vec),
    .flush   (flush),
    .busy    (busy)
  );

  assign issue_waw = busy[issue_rd];

endmodule
